// File: rtl/zorro_int_pkg.sv
// Shared constants for the Zorro interrupt controller: register offsets,
// CTRL bit positions and bus FSM encoding.
package zorro_int_pkg;

    localparam logic [27:0] OFF_STATUS = 28'h00;
    localparam logic [27:0] OFF_VECTOR = 28'h04;
    localparam logic [27:0] OFF_MASK   = 28'h08;
    localparam logic [27:0] OFF_MODE   = 28'h0C;
    localparam logic [27:0] OFF_CTRL   = 28'h10;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_COR = 1;

    localparam logic [7:0] CTRL_RESET = 8'h01;
    localparam logic [7:0] DOUT_IDLE  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_RELEASE = 2'd2
    } bus_state_t;

endpackage

// File: rtl/int_src_sync.sv
// Two-flop synchronizer for one asynchronous interrupt line, plus a
// rising-edge detector on the synchronized level.
module int_src_sync (
    input  logic clk,
    input  logic reset,
    input  logic src,
    output logic level,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= src;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~sync_d;

endmodule

// File: rtl/zorro_int_ctrl.sv
// Zorro bus slave interrupt controller: per-source edge/level pending bits,
// mask, global enable, and a three-state acknowledge FSM for register access.
module zorro_int_ctrl
    import zorro_int_pkg::*;
#(
    parameter int          NUM_SRC   = 4,
    parameter logic [27:0] BASE_ADDR = 28'h900000,
    parameter logic [7:0]  VEC_RESET = 8'h18
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [27:0]        ADDR,
    input  logic               READ,
    input  logic               FCS_n,
    input  logic               slave_cycle,
    input  logic               configured,
    input  logic [7:0]         DIN,
    input  logic [NUM_SRC-1:0] INT_SRC,
    output logic               int_dtack,
    output logic               INT_n,
    output logic [7:0]         DOUT,
    output bus_state_t         bus_state
);

    logic [NUM_SRC-1:0] src_level;
    logic [NUM_SRC-1:0] src_rise;
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] mode;
    logic [NUM_SRC-1:0] clr;
    logic [7:0]         vector;
    logic [7:0]         ctrl;
    logic [27:0]        offset;
    logic               mapped;
    logic               fire;
    logic [7:0]         rd_data;
    logic               unused_addr0;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_sync
            int_src_sync u_sync (
                .clk   (CLK),
                .reset (RESET),
                .src   (INT_SRC[g]),
                .level (src_level[g]),
                .rise  (src_rise[g])
            );
        end
    endgenerate

    // Level-mode bits follow the synchronized input directly, so they cannot be cleared.
    assign pending = (mode & src_level) | (~mode & pend_q);

    assign offset       = {ADDR[27:1], 1'b0} - BASE_ADDR;
    assign unused_addr0 = ADDR[0];

    always_comb begin
        mapped  = 1'b1;
        rd_data = 8'h00;
        case (offset)
            OFF_STATUS: rd_data[NUM_SRC-1:0] = pending;
            OFF_VECTOR: rd_data = vector;
            OFF_MASK:   rd_data[NUM_SRC-1:0] = mask;
            OFF_MODE:   rd_data[NUM_SRC-1:0] = mode;
            OFF_CTRL:   rd_data = ctrl;
            default: begin
                mapped  = 1'b0;
                rd_data = DOUT_IDLE;
            end
        endcase
    end

    assign fire = (bus_state == ST_IDLE) && slave_cycle && configured && !FCS_n && mapped;

    always_comb begin
        clr = '0;
        if (fire && offset == OFF_STATUS) begin
            if (READ) begin
                if (ctrl[CTRL_COR]) clr = '1;
            end else begin
                clr = DIN[NUM_SRC-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend_q    <= '0;
            mask      <= '0;
            mode      <= '0;
            ctrl      <= CTRL_RESET;
            vector    <= VEC_RESET;
            bus_state <= ST_IDLE;
            int_dtack <= 1'b0;
            INT_n     <= 1'b1;
            DOUT      <= DOUT_IDLE;
        end else begin
            // A new edge wins over a clear landing in the same cycle.
            pend_q <= ((pend_q & ~clr) | src_rise) & ~mode;
            INT_n  <= ~(ctrl[CTRL_EN] & (|(pending & mask)));
            case (bus_state)
                ST_IDLE: begin
                    if (fire) begin
                        bus_state <= ST_ACK;
                        int_dtack <= 1'b1;
                        DOUT      <= READ ? rd_data : DOUT_IDLE;
                        if (!READ) begin
                            case (offset)
                                OFF_VECTOR: vector <= DIN;
                                OFF_MASK:   mask   <= DIN[NUM_SRC-1:0];
                                OFF_MODE:   mode   <= DIN[NUM_SRC-1:0];
                                OFF_CTRL:   ctrl   <= DIN;
                                default:    ;
                            endcase
                        end
                    end
                end
                ST_ACK: begin
                    if (FCS_n) begin
                        bus_state <= ST_IDLE;
                        int_dtack <= 1'b0;
                        DOUT      <= DOUT_IDLE;
                    end else begin
                        bus_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (FCS_n) begin
                        bus_state <= ST_IDLE;
                        int_dtack <= 1'b0;
                        DOUT      <= DOUT_IDLE;
                    end
                end
                default: begin
                    bus_state <= ST_IDLE;
                    int_dtack <= 1'b0;
                    DOUT      <= DOUT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zorro_int_ctrl.sv
// Directed bench for zorro_int_ctrl: register table plus interrupt,
// clear-on-read, level mode, set priority and mid-access reset sequences.
module tb_zorro_int_ctrl;
    import zorro_int_pkg::*;

    localparam int          NS   = 4;
    localparam logic [27:0] BASE = 28'h900000;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [27:0]   ADDR = '0;
    logic          READ = 1'b0;
    logic          FCS_n = 1'b1;
    logic          slave_cycle = 1'b0;
    logic          configured = 1'b0;
    logic [7:0]    DIN = '0;
    logic [NS-1:0] INT_SRC = '0;
    logic          int_dtack;
    logic          INT_n;
    logic [7:0]    DOUT;
    bus_state_t    bus_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic       ack;
    logic [7:0] rdv;

    typedef struct {
        logic       rd;
        logic       cfg;
        logic [7:0] off;
        logic [7:0] wdata;
        logic       exp_ack;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[20];

    zorro_int_ctrl #(.NUM_SRC(NS), .BASE_ADDR(BASE), .VEC_RESET(8'h18)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ADDR        (ADDR),
        .READ        (READ),
        .FCS_n       (FCS_n),
        .slave_cycle (slave_cycle),
        .configured  (configured),
        .DIN         (DIN),
        .INT_SRC     (INT_SRC),
        .int_dtack   (int_dtack),
        .INT_n       (INT_n),
        .DOUT        (DOUT),
        .bus_state   (bus_state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One bus access; mid_pulse is raised on INT_SRC for one cycle during the hold.
    task automatic bus_access(input logic rd, input logic cfg, input logic [7:0] off,
                              input logic [7:0] wdata, input int hold,
                              input logic [NS-1:0] mid_pulse,
                              output logic acked, output logic [7:0] rdata);
        int n;
        ADDR        = BASE + {20'h0, off};
        READ        = rd;
        DIN         = wdata;
        slave_cycle = 1'b1;
        configured  = cfg;
        FCS_n       = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!int_dtack && n < 4);
        acked = int_dtack;
        rdata = DOUT;
        for (int i = 0; i < hold; i++) begin
            if (i == 1) INT_SRC = INT_SRC | mid_pulse;
            if (i == 2) INT_SRC = INT_SRC & ~mid_pulse;
            tick();
            if (acked) chk("dtack_hold", int_dtack, 1);
        end
        FCS_n       = 1'b1;
        READ        = 1'b0;
        slave_cycle = 1'b0;
        tick();
        chk("dtack_release", int_dtack, 0);
    endtask

    task automatic wr(input logic [7:0] off, input logic [7:0] data);
        bus_access(1'b0, 1'b1, off, data, 0, '0, ack, rdv);
        chk("wr_ack", ack, 1);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] off, input logic [7:0] exp);
        bus_access(1'b1, 1'b1, off, 8'h00, 0, '0, ack, rdv);
        chk(name, rdv, exp);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 8'h04, 8'h00, 1'b1, 8'h18};
        vecs[1]  = '{1'b1, 1'b1, 8'h10, 8'h00, 1'b1, 8'h01};
        vecs[2]  = '{1'b1, 1'b1, 8'h08, 8'h00, 1'b1, 8'h00};
        vecs[3]  = '{1'b1, 1'b1, 8'h0C, 8'h00, 1'b1, 8'h00};
        vecs[4]  = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00};
        vecs[5]  = '{1'b1, 1'b1, 8'h14, 8'h00, 1'b0, 8'hFF};
        vecs[6]  = '{1'b0, 1'b1, 8'h14, 8'h77, 1'b0, 8'hFF};
        vecs[7]  = '{1'b0, 1'b1, 8'h04, 8'h40, 1'b1, 8'hFF};
        vecs[8]  = '{1'b1, 1'b1, 8'h04, 8'h00, 1'b1, 8'h40};
        vecs[9]  = '{1'b0, 1'b0, 8'h04, 8'h55, 1'b0, 8'hFF};
        vecs[10] = '{1'b1, 1'b1, 8'h04, 8'h00, 1'b1, 8'h40};
        vecs[11] = '{1'b0, 1'b1, 8'h08, 8'hFF, 1'b1, 8'hFF};
        vecs[12] = '{1'b1, 1'b1, 8'h08, 8'h00, 1'b1, 8'h0F};
        vecs[13] = '{1'b0, 1'b1, 8'h0C, 8'h0A, 1'b1, 8'hFF};
        vecs[14] = '{1'b1, 1'b1, 8'h0C, 8'h00, 1'b1, 8'h0A};
        vecs[15] = '{1'b0, 1'b1, 8'h0C, 8'h00, 1'b1, 8'hFF};
        vecs[16] = '{1'b0, 1'b1, 8'h08, 8'h00, 1'b1, 8'hFF};
        vecs[17] = '{1'b0, 1'b1, 8'h10, 8'hA5, 1'b1, 8'hFF};
        vecs[18] = '{1'b1, 1'b1, 8'h10, 8'h00, 1'b1, 8'hA5};
        vecs[19] = '{1'b0, 1'b1, 8'h10, 8'h01, 1'b1, 8'hFF};

        // Reset
        repeat (3) tick();
        RESET = 1'b0;
        tick();
        chk("rst_dtack", int_dtack, 0);
        chk("rst_int_n", INT_n, 1);
        chk("rst_dout", DOUT, 8'hFF);
        chk("rst_state", bus_state, ST_IDLE);

        // Register table
        for (int i = 0; i < 20; i++) begin
            bus_access(vecs[i].rd, vecs[i].cfg, vecs[i].off, vecs[i].wdata, 0, '0, ack, rdv);
            chk($sformatf("vec%0d_ack", i), ack, vecs[i].exp_ack);
            chk($sformatf("vec%0d_dout", i), rdv, vecs[i].exp_dout);
        end

        // Edge interrupt raises INT_n within 4 cycles, W1C drops it one cycle later
        wr(8'h08, 8'h01);
        INT_SRC[0] = 1'b1;
        tick();
        INT_SRC[0] = 1'b0;
        for (int n = 1; n < 4 && INT_n; n++) tick();
        chk("edge_int_n_low", INT_n, 0);
        wr(8'h00, 8'h01);
        chk("w1c_int_n_high", INT_n, 1);
        rd_chk("w1c_status", 8'h00, 8'h00);
        wr(8'h08, 8'h00);

        // Clear-on-read with a long strobe: one clear only
        wr(8'h10, 8'h03);
        INT_SRC = 4'b0101;
        tick();
        INT_SRC = 4'b0000;
        repeat (4) tick();
        bus_access(1'b1, 1'b1, 8'h00, 8'h00, 10, 4'b0010, ack, rdv);
        chk("cor_ack", ack, 1);
        chk("cor_dout", rdv, 8'h05);
        rd_chk("cor_single_clear", 8'h00, 8'h02);
        rd_chk("cor_cleared", 8'h00, 8'h00);
        wr(8'h10, 8'h01);

        // Level mode: not clearable, follows the synchronized input
        wr(8'h0C, 8'h02);
        INT_SRC[1] = 1'b1;
        repeat (3) tick();
        wr(8'h00, 8'h02);
        rd_chk("level_held", 8'h00, 8'h02);
        INT_SRC[1] = 1'b0;
        repeat (2) tick();
        rd_chk("level_released", 8'h00, 8'h00);
        wr(8'h0C, 8'h00);

        // Edge arriving in the same cycle as its W1C stays pending
        INT_SRC[2] = 1'b1;
        repeat (2) tick();
        wr(8'h00, 8'h04);
        rd_chk("set_priority", 8'h00, 8'h04);
        wr(8'h00, 8'h04);
        rd_chk("later_clear", 8'h00, 8'h00);
        INT_SRC[2] = 1'b0;

        // Reset asserted while the FSM sits in RELEASE
        wr(8'h04, 8'h40);
        wr(8'h08, 8'h01);
        INT_SRC[0] = 1'b1;
        tick();
        INT_SRC[0] = 1'b0;
        repeat (4) tick();
        chk("pre_rst_int_n", INT_n, 0);
        ADDR        = BASE + 28'h04;
        READ        = 1'b1;
        slave_cycle = 1'b1;
        configured  = 1'b1;
        FCS_n       = 1'b0;
        tick();
        chk("mid_ack_dtack", int_dtack, 1);
        chk("mid_ack_dout", DOUT, 8'h40);
        tick();
        chk("mid_release_state", bus_state, ST_RELEASE);
        RESET = 1'b1;
        tick();
        chk("midrst_dtack", int_dtack, 0);
        chk("midrst_int_n", INT_n, 1);
        chk("midrst_state", bus_state, ST_IDLE);
        RESET       = 1'b0;
        FCS_n       = 1'b1;
        READ        = 1'b0;
        slave_cycle = 1'b0;
        tick();
        rd_chk("midrst_vector", 8'h04, 8'h18);
        rd_chk("midrst_mask", 8'h08, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
